z80_int_ctrl: RTL and testbench

//  - Interrupt controller directly upstream of the z80 core; drives its INT_L and NMI_L inputs.
//  - Collects NUM_SRC peripheral requests and fixes priority (lowest index wins).
//  - Answers the core's interrupt-acknowledge cycle (M1_L & IORQ_L both low) with a mode-2 vector on the core's data_in.
//  - Stretches an external NMI edge into a clean NMI_L pulse.

---
 rtl/z80_int_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_int_ctrl.sv
// -----------------------------------------------------------------------------
// z80_int_ctrl
//
// Purpose:
//   Interrupt controller that sits directly in front of a z80 core. It collects
//   NUM_SRC maskable peripheral requests, arbitrates them with fixed priority
//   (lowest index wins), drives the core's active-low INT_L, and answers the
//   interrupt-acknowledge cycle (M1_L and IORQ_L both low) with a mode-2
//   vector byte. Separately, it turns a rising edge on nmi_in into a clean
//   NMI_L low pulse of NMI_PULSE clock cycles.
//
// Build option:
//   Z80_INT_LEVEL_EN  defined     -> sources are level-sensitive: pending
//                                    mirrors irq_in, a grant does not clear
//                                    it, and the post-grant gap is 2 cycles.
//                     not defined -> rising edges are latched into pending and
//                                    a grant clears the granted bit (default).
//
// Parameters:
//   NUM_SRC    number of maskable sources, 1..8
//   VEC_BASE   vector base byte, low 4 bits must be zero
//   NMI_PULSE  NMI_L low time in clk cycles, >= 1
//
// Ports:
//   clk        in   system clock (same clock as the z80 core)
//   rst        in   synchronous active-high reset
//   irq_in     in   [NUM_SRC] peripheral requests
//   irq_mask   in   [NUM_SRC] 1 = masked (still recorded, never granted)
//   nmi_in     in   external non-maskable request, rising-edge sensitive
//   M1_L       in   core M1, active low
//   IORQ_L     in   core IORQ, active low
//   INT_L      out  maskable interrupt request to the core, active low
//   NMI_L      out  NMI pulse to the core, active low
//   vec_data   out  [8] vector byte for the core data bus
//   vec_oe     out  vector drive enable (mux select onto core data_in)
//   pending    out  [NUM_SRC] pending status
//   ack_idx    out  [3] index of the last granted source
// -----------------------------------------------------------------------------
module z80_int_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] VEC_BASE  = 8'hE0,
  parameter int         NMI_PULSE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               nmi_in,
  input  logic               M1_L,
  input  logic               IORQ_L,
  output logic               INT_L,
  output logic               NMI_L,
  output logic [7:0]         vec_data,
  output logic               vec_oe,
  output logic [NUM_SRC-1:0] pending,
  output logic [2:0]         ack_idx
);

  localparam int NMI_W = $clog2(NMI_PULSE + 1);

  // Extra GAP cycles beyond the first one. Level mode needs one more cycle so
  // a peripheral that dropped its line after the grant is seen before the
  // next arbitration.
`ifdef Z80_INT_LEVEL_EN
  localparam logic GAP_EXTRA = 1'b1;
`else
  localparam logic GAP_EXTRA = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_ACK,
    ST_GAP
  } state_t;

  state_t state_q, state_d;

  logic               int_l_q,    int_l_d;
  logic               vec_oe_q,   vec_oe_d;
  logic [7:0]         vec_data_q, vec_data_d;
  logic [2:0]         ack_idx_q,  ack_idx_d;
  logic               gap_left_q, gap_left_d;

  logic               intack;
  logic [NUM_SRC-1:0] pend_eff;
  logic [NUM_SRC-1:0] eligible;
  logic               req;
  logic [2:0]         win;
  logic               grant_fire;

  // Acknowledge cycle as seen by the core bus at this clock edge.
  assign intack = ~M1_L & ~IORQ_L;

  // ---------------------------------------------------------------------------
  // Pending register
  // ---------------------------------------------------------------------------
`ifdef Z80_INT_LEVEL_EN
  // Level mode: status is the live request lines; the peripheral must drop
  // its line to retire the request.
  assign pend_eff = irq_in;
`else
  logic [NUM_SRC-1:0] irq_hist_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] grant_clr;

  // History loads 0 in reset, so a line already high right after reset is
  // taken as a fresh edge.
  assign irq_rise = irq_in & ~irq_hist_q;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
    assign grant_clr[gi] = grant_fire && (win == 3'(gi));
  end

  // A new edge beats a grant clear of the same bit, so a request arriving on
  // the acknowledge edge is not lost.
  assign pending_d = (pending_q & ~grant_clr) | irq_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_hist_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_hist_q <= irq_in;
      pending_q  <= pending_d;
    end
  end

  assign pend_eff = pending_q;
`endif

  assign pending = pend_eff;

  // ---------------------------------------------------------------------------
  // Arbitration: lowest unmasked pending index wins. Re-evaluated every cycle,
  // so a higher-priority source arriving while INT_L is low takes the grant.
  // ---------------------------------------------------------------------------
  assign eligible = pend_eff & ~irq_mask;
  assign req      = |eligible;

  always_comb begin
    win = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Maskable interrupt FSM: next-state and registered-output values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    int_l_d    = 1'b1;
    vec_oe_d   = vec_oe_q;
    vec_data_d = vec_data_q;
    ack_idx_d  = ack_idx_q;
    gap_left_d = gap_left_q;
    grant_fire = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (intack) begin
          // Acknowledge without a request outstanding: answer with 0xFF and
          // hold off raising INT_L until the core leaves the cycle.
          vec_oe_d   = 1'b1;
          vec_data_d = 8'hFF;
        end else begin
          vec_oe_d = 1'b0;
          if (req) begin
            state_d = ST_ASSERT;
            int_l_d = 1'b0;
          end
        end
      end

      ST_ASSERT: begin
        if (!req) begin
          // Request withdrawn (masked) before the core acknowledged.
          state_d = ST_IDLE;
          if (intack) begin
            vec_oe_d   = 1'b1;
            vec_data_d = 8'hFF;
          end else begin
            vec_oe_d = 1'b0;
          end
        end else if (intack) begin
          grant_fire = 1'b1;
          ack_idx_d  = win;
          vec_data_d = VEC_BASE | {4'h0, win, 1'b0};
          vec_oe_d   = 1'b1;
          state_d    = ST_ACK;
        end else begin
          int_l_d  = 1'b0;
          vec_oe_d = 1'b0;
        end
      end

      ST_ACK: begin
        if (!intack) begin
          vec_oe_d   = 1'b0;
          gap_left_d = GAP_EXTRA;
          state_d    = ST_GAP;
        end else begin
          vec_oe_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (intack) begin
          vec_oe_d   = 1'b1;
          vec_data_d = 8'hFF;
        end else begin
          vec_oe_d = 1'b0;
        end
        if (gap_left_q == 1'b0) begin
          state_d = ST_IDLE;
        end else begin
          gap_left_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        vec_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      int_l_q    <= 1'b1;
      vec_oe_q   <= 1'b0;
      vec_data_q <= 8'h00;
      ack_idx_q  <= 3'd0;
      gap_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_l_q    <= int_l_d;
      vec_oe_q   <= vec_oe_d;
      vec_data_q <= vec_data_d;
      ack_idx_q  <= ack_idx_d;
      gap_left_q <= gap_left_d;
    end
  end

  assign INT_L    = int_l_q;
  assign vec_oe   = vec_oe_q;
  assign vec_data = vec_data_q;
  assign ack_idx  = ack_idx_q;

  // ---------------------------------------------------------------------------
  // NMI pulse stretcher. An edge (re)loads the down-counter, so an edge during
  // an active pulse extends it. NMI_L is registered so the counter compare
  // cannot glitch the core's NMI input.
  // ---------------------------------------------------------------------------
  logic             nmi_hist_q;
  logic [NMI_W-1:0] nmi_cnt_q, nmi_cnt_d;
  logic             nmi_l_q;

  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (nmi_in && !nmi_hist_q) begin
      nmi_cnt_d = NMI_W'(NMI_PULSE);
    end else if (nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - NMI_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_hist_q <= 1'b0;
      nmi_cnt_q  <= '0;
      nmi_l_q    <= 1'b1;
    end else begin
      nmi_hist_q <= nmi_in;
      nmi_cnt_q  <= nmi_cnt_d;
      nmi_l_q    <= (nmi_cnt_d == '0);
    end
  end

  assign NMI_L = nmi_l_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z80_int_ctrl
//
// Directed bench for z80_int_ctrl (default edge-latched build). Stimulus pushes
// the expected acknowledge vectors and NMI pulse widths into queues; monitor
// processes pop and compare whenever the DUT raises vec_oe or ends an NMI_L
// pulse. Inline checks cover INT_L, pending and reset state.
// -----------------------------------------------------------------------------
module tb_z80_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] irq_mask;
  logic       nmi_in;
  logic       M1_L;
  logic       IORQ_L;
  logic       INT_L;
  logic       NMI_L;
  logic [7:0] vec_data;
  logic       vec_oe;
  logic [7:0] pending;
  logic [2:0] ack_idx;

  always #5 clk = ~clk;

  z80_int_ctrl #(
    .NUM_SRC  (8),
    .VEC_BASE (8'hE0),
    .NMI_PULSE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_mask(irq_mask),
    .nmi_in  (nmi_in),
    .M1_L    (M1_L),
    .IORQ_L  (IORQ_L),
    .INT_L   (INT_L),
    .NMI_L   (NMI_L),
    .vec_data(vec_data),
    .vec_oe  (vec_oe),
    .pending (pending),
    .ack_idx (ack_idx)
  );

  typedef struct {
    logic [7:0] vec;
    logic       chk_idx;
    logic [2:0] idx;
  } ack_exp_t;

  ack_exp_t ack_q[$];
  int       nmi_q[$];
  int       errors = 0;
  int       checks = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic [7:0] v, input logic ci, input logic [2:0] idx);
    ack_exp_t e;
    e.vec     = v;
    e.chk_idx = ci;
    e.idx     = idx;
    ack_q.push_back(e);
  endtask

  task automatic wait_int_low();
    int n = 0;
    while (INT_L !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("int_l_asserted", 32'(INT_L), 0);
  endtask

  // Full grant: wait for INT_L, acknowledge for 2 cycles, release.
  task automatic grant(input logic [7:0] v, input logic [2:0] idx);
    wait_int_low();
    push_ack(v, 1'b1, idx);
    M1_L = 1'b0; IORQ_L = 1'b0;
    cyc(2);
    M1_L = 1'b1; IORQ_L = 1'b1;
    cyc(1);
    chk("grant_oe_off", 32'(vec_oe), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic     oe_prev = 1'b0;
  int       nmi_low = 0;
  ack_exp_t mon_e;
  int       mon_n;

  always @(negedge clk) begin
    if (vec_oe === 1'b1 && oe_prev !== 1'b1) begin
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got vec=%02h, none expected", vec_data);
      end else begin
        mon_e = ack_q.pop_front();
        $display("ack vec=%02h idx=%0d (exp vec=%02h)", vec_data, ack_idx, mon_e.vec);
        chk("ack_vec", 32'(vec_data), 32'(mon_e.vec));
        if (mon_e.chk_idx) chk("ack_idx", 32'(ack_idx), 32'(mon_e.idx));
      end
    end
    oe_prev = vec_oe;

    if (NMI_L === 1'b0) begin
      nmi_low++;
    end else if (NMI_L === 1'b1 && nmi_low != 0) begin
      if (nmi_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nmi_unexpected: got pulse of %0d cycles, none expected", nmi_low);
      end else begin
        mon_n = nmi_q.pop_front();
        $display("nmi pulse len=%0d (exp %0d)", nmi_low, mon_n);
        chk("nmi_len", 32'(nmi_low), 32'(mon_n));
      end
      nmi_low = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; irq_in = 8'hFF; irq_mask = 8'h00; nmi_in = 1'b0;
    M1_L = 1'b1; IORQ_L = 1'b1;

    // T1: reset with all requests high
    cyc(3);
    chk("t1_rst_int_l",   32'(INT_L),   1);
    chk("t1_rst_nmi_l",   32'(NMI_L),   1);
    chk("t1_rst_vec_oe",  32'(vec_oe),  0);
    chk("t1_rst_pending", 32'(pending), 0);
    chk("t1_rst_vec",     32'(vec_data), 0);
    chk("t1_rst_ack_idx", 32'(ack_idx), 0);
    rst = 1'b0;
    cyc(1);
    chk("t1_pending_ff", 32'(pending), 32'hFF);
    irq_in = 8'h00;
    // Drain in priority order
    for (int i = 0; i < 8; i++) begin
      grant(8'hE0 | 8'(2 * i), 3'(i));
    end
    cyc(3);
    chk("t1_drained", 32'(pending), 0);
    chk("t1_idle_int_l", 32'(INT_L), 1);

    // T2: single grant of source 3
    irq_in = 8'h08;
    cyc(1);
    irq_in = 8'h00;
    chk("t2_pending_set", 32'(pending), 32'h08);
    chk("t2_int_l_not_yet", 32'(INT_L), 1);
    cyc(1);
    chk("t2_int_l_low", 32'(INT_L), 0);
    push_ack(8'hE6, 1'b1, 3'd3);
    M1_L = 1'b0; IORQ_L = 1'b0;
    cyc(1);
    chk("t2_vec_oe", 32'(vec_oe), 1);
    chk("t2_ack_idx", 32'(ack_idx), 3);
    chk("t2_pending_clr", 32'(pending), 0);
    chk("t2_ack_int_l", 32'(INT_L), 1);
    cyc(1);
    M1_L = 1'b1; IORQ_L = 1'b1;
    cyc(1);
    chk("t2_oe_off", 32'(vec_oe), 0);
    chk("t2_gap_int_l", 32'(INT_L), 1);
    cyc(1);
    chk("t2_gap2_int_l", 32'(INT_L), 1);

    // T3: priority with mask
    irq_mask = 8'h04;
    irq_in = 8'h24;
    cyc(1);
    irq_in = 8'h00;
    chk("t3_pending", 32'(pending), 32'h24);
    grant(8'hEA, 3'd5);
    chk("t3_pending_left", 32'(pending), 32'h04);
    cyc(3);
    chk("t3_masked_int_l", 32'(INT_L), 1);
    irq_mask = 8'h00;
    grant(8'hE4, 3'd2);
    chk("t3_pending_done", 32'(pending), 0);

    // T4: withdraw by mask while asserting, then spurious ack
    irq_in = 8'h02;
    cyc(1);
    irq_in = 8'h00;
    wait_int_low();
    irq_mask = 8'h02;
    cyc(1);
    chk("t4_withdraw_int_l", 32'(INT_L), 1);
    chk("t4_pending_kept", 32'(pending), 32'h02);
    cyc(1);
    chk("t4_idle_int_l", 32'(INT_L), 1);
    push_ack(8'hFF, 1'b0, 3'd0);
    M1_L = 1'b0; IORQ_L = 1'b0;
    cyc(2);
    M1_L = 1'b1; IORQ_L = 1'b1;
    cyc(2);
    chk("t4_spur_oe_off", 32'(vec_oe), 0);
    chk("t4_spur_pending", 32'(pending), 32'h02);
    irq_mask = 8'h00;
    grant(8'hE2, 3'd1);

    // T5: NMI single pulse, then stretched pulse with a concurrent grant
    nmi_q.push_back(4);
    nmi_in = 1'b1;
    cyc(1);
    nmi_in = 1'b0;
    chk("t5_nmi_low", 32'(NMI_L), 0);
    cyc(6);
    fork
      begin
        nmi_q.push_back(6);
        nmi_in = 1'b1;
        cyc(1);
        nmi_in = 1'b0;
        cyc(1);
        nmi_in = 1'b1;
        cyc(1);
        nmi_in = 1'b0;
        cyc(8);
      end
      begin
        irq_in = 8'h01;
        cyc(1);
        irq_in = 8'h00;
        grant(8'hE0, 3'd0);
      end
    join
    chk("t5_nmi_idle", 32'(NMI_L), 1);

    // T6: new edge on source 0 lands on its own grant edge
    irq_in = 8'h01;
    cyc(1);
    irq_in = 8'h00;
    wait_int_low();
    push_ack(8'hE0, 1'b1, 3'd0);
    M1_L = 1'b0; IORQ_L = 1'b0;
    irq_in = 8'h01;
    cyc(1);
    chk("t6_set_wins", 32'(pending), 32'h01);
    irq_in = 8'h00;
    cyc(1);
    M1_L = 1'b1; IORQ_L = 1'b1;
    cyc(1);
    chk("t6_gap_int_l", 32'(INT_L), 1);
    cyc(1);
    chk("t6_idle_int_l", 32'(INT_L), 1);
    cyc(1);
    chk("t6_reassert", 32'(INT_L), 0);
    grant(8'hE0, 3'd0);
    chk("t6_pending_done", 32'(pending), 0);

    // Reset in the middle of an acknowledge
    irq_in = 8'h10;
    cyc(1);
    irq_in = 8'h00;
    wait_int_low();
    push_ack(8'hE8, 1'b1, 3'd4);
    M1_L = 1'b0; IORQ_L = 1'b0;
    cyc(1);
    chk("rst_mid_oe_on", 32'(vec_oe), 1);
    rst = 1'b1;
    M1_L = 1'b1; IORQ_L = 1'b1;
    cyc(1);
    chk("rst_mid_oe_off", 32'(vec_oe), 0);
    chk("rst_mid_int_l", 32'(INT_L), 1);
    chk("rst_mid_ack_idx", 32'(ack_idx), 0);
    rst = 1'b0;
    cyc(5);

    chk("ack_queue_empty", 32'(ack_q.size()), 0);
    chk("nmi_queue_empty", 32'(nmi_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
